// File: rtl/msg_scroller.sv
// msg_scroller: two-half BCD number entry from switches, then a registered four-digit scrolling window.
// Optional `BCD_CHECK_EN rejects loads containing a nibble above 9 and pulses err.
module msg_scroller #(
  parameter int STEP_CYCLES = 95,
  parameter int GAP = 4
) (
  input  logic        clk190hz,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        btn_load,
  input  logic        btn_run,
  input  logic        btn_back,
  output logic [31:0] number,
  output logic [15:0] data_bus,
  output logic        entry_hi,
  output logic        scrolling,
  output logic        paused,
  output logic        err
);
  localparam int L = 8 + GAP;
  localparam int TW = $clog2(STEP_CYCLES);
  localparam int MW = 4 * L + 12;
  typedef enum logic [1:0] {S_HI, S_LO, S_SC} state_t;
  state_t r_state, w_state_n;
  logic [2:0] r_s0, r_s1, r_s2, w_ev;
  logic w_back, w_load, w_run, w_bad, w_commit, w_start, w_adv, w_wrap;
  logic [31:0] r_number, w_num_n;
  logic [15:0] r_data;
  logic [3:0] r_pos, w_pos_n;
  logic [TW-1:0] r_tick, w_tick_n;
  logic r_paused, w_paused_n;
  logic [MW-1:0] w_rot;
  // Preset high so a button held through reset reads as already pressed and needs a release first.
  always_ff @(posedge clk190hz)
    if (reset) begin
      r_s0 <= '1;
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s0 <= {btn_back, btn_load, btn_run};
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  assign w_ev = r_s1 & ~r_s2;
  assign w_back = w_ev[2];
  assign w_load = w_ev[1] & ~w_ev[2];
  assign w_run = w_ev[0] & ~|w_ev[2:1];
`ifdef BCD_CHECK_EN
  assign w_bad = (sw[15:12] > 4'd9) | (sw[11:8] > 4'd9) | (sw[7:4] > 4'd9) | (sw[3:0] > 4'd9);
  logic r_err;
  always_ff @(posedge clk190hz)
    if (reset) r_err <= 1'b0;
    else r_err <= w_load & w_bad & (r_state != S_SC);
  assign err = r_err;
`else
  assign w_bad = 1'b0;
  assign err = 1'b0;
`endif
  assign w_commit = w_load & ~w_bad & (r_state != S_SC);
  assign w_start = w_commit & (r_state == S_LO);
  always_ff @(posedge clk190hz)
    if (reset) r_state <= S_HI;
    else r_state <= w_state_n;
  always_comb
    w_state_n = w_back ? S_HI : w_commit ? (r_state == S_HI ? S_LO : S_SC) : r_state;
  // The edge that toggles pause, and the edge that resumes, leave tick untouched.
  always_comb begin
    w_adv = (r_state == S_SC) & ~r_paused & ~w_run & ~w_back;
    w_wrap = w_adv & (r_tick == TW'(STEP_CYCLES - 1));
    w_num_n = w_back ? '0 : (w_commit & (r_state == S_HI)) ? {sw, r_number[15:0]} :
              w_commit ? {r_number[31:16], sw} : r_number;
    w_tick_n = (w_back | w_start | w_wrap) ? '0 : w_adv ? r_tick + 1'b1 : r_tick;
    w_pos_n = (w_back | w_start) ? '0 : w_wrap ? (r_pos == 4'(L - 1) ? '0 : r_pos + 1'b1) : r_pos;
    w_paused_n = (w_back | w_start) ? 1'b0 : ((r_state == S_SC) & w_run) ? ~r_paused : r_paused;
    w_rot = {w_num_n, {GAP{4'hB}}, w_num_n[31:20]} << {w_pos_n, 2'b00};
  end
  always_ff @(posedge clk190hz)
    if (reset) begin
      r_number <= '0;
      r_data <= 16'hBBBB;
      r_pos <= '0;
      r_tick <= '0;
      r_paused <= 1'b0;
    end else begin
      r_number <= w_num_n;
      r_data <= (w_state_n == S_SC) ? w_rot[MW-1 -: 16] : sw;
      r_pos <= w_pos_n;
      r_tick <= w_tick_n;
      r_paused <= w_paused_n;
    end
  always_comb begin
    entry_hi = r_state == S_HI;
    scrolling = r_state == S_SC;
    number = r_number;
    data_bus = r_data;
    paused = r_paused;
  end
endmodule

// File: tb/tb_msg_scroller.sv
// tb_msg_scroller: directed checks of entry, scrolling, pause, back priority, BCD check and reset.
module tb_msg_scroller;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] sw = '0;
  logic btn_load = 1'b0, btn_run = 1'b0, btn_back = 1'b0;
  logic [31:0] number;
  logic [15:0] data_bus;
  logic entry_hi, scrolling, paused, err;
  int checks = 0, failures = 0;
  logic [15:0] seq [0:12] = '{16'h4122, 16'h1221, 16'h2212, 16'h2123, 16'h1234, 16'h234B, 16'h34BB,
                              16'h4BBB, 16'hBBBB, 16'hBBB4, 16'hBB41, 16'hB412, 16'h4122};
  always #5 clk = ~clk;
  msg_scroller #(.STEP_CYCLES(4), .GAP(4)) dut (
    .clk190hz(clk), .reset(reset), .sw(sw), .btn_load(btn_load), .btn_run(btn_run),
    .btn_back(btn_back), .number(number), .data_bus(data_bus), .entry_hi(entry_hi),
    .scrolling(scrolling), .paused(paused), .err(err)
  );
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [2:0] m);
    {btn_back, btn_load, btn_run} = m;
    idle(3);
    {btn_back, btn_load, btn_run} = 3'b000;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    sw = 16'h4122;
    idle(2);
    checks++; if (number !== 32'h0) begin failures++; $display("FAIL reset_number got=%h exp=%h", number, 32'h0); end
    checks++; if (data_bus !== 16'hBBBB) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_bus, 16'hBBBB); end
    checks++; if ({entry_hi, scrolling, paused, err} !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {entry_hi, scrolling, paused, err}, 4'b1000); end
    reset = 1'b0;
    idle(1);
    checks++; if (data_bus !== 16'h4122) begin failures++; $display("FAIL preview_hi got=%h exp=%h", data_bus, 16'h4122); end
    idle(2);
  endtask
  task automatic test_load;
    press(3'b010);
    checks++; if (number !== 32'h41220000) begin failures++; $display("FAIL load_hi got=%h exp=%h", number, 32'h41220000); end
    checks++; if ({entry_hi, scrolling} !== 2'b00) begin failures++; $display("FAIL entry_lo_flags got=%b exp=%b", {entry_hi, scrolling}, 2'b00); end
    sw = 16'h1234;
    idle(1);
    checks++; if (data_bus !== 16'h1234) begin failures++; $display("FAIL preview_lo got=%h exp=%h", data_bus, 16'h1234); end
    idle(2);
    press(3'b010);
    checks++; if (number !== 32'h41221234) begin failures++; $display("FAIL load_lo got=%h exp=%h", number, 32'h41221234); end
    checks++; if ({scrolling, paused} !== 2'b10) begin failures++; $display("FAIL scroll_flags got=%b exp=%b", {scrolling, paused}, 2'b10); end
    checks++; if (data_bus !== 16'h4122) begin failures++; $display("FAIL scroll_entry got=%h exp=%h", data_bus, 16'h4122); end
  endtask
  task automatic test_scroll;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        idle(3);
        checks++; if (data_bus !== 16'h4122) begin failures++; $display("FAIL early_shift got=%h exp=%h", data_bus, 16'h4122); end
        idle(1);
      end else idle(4);
      checks++; if (data_bus !== seq[k]) begin failures++; $display("FAIL scroll_step%0d got=%h exp=%h", k, data_bus, seq[k]); end
    end
  endtask
  task automatic test_pause;
    press(3'b001);
    checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_set got=%b exp=1", paused); end
    idle(100);
    checks++; if (data_bus !== 16'h4122) begin failures++; $display("FAIL pause_frozen got=%h exp=%h", data_bus, 16'h4122); end
    checks++; if ({scrolling, paused} !== 2'b11) begin failures++; $display("FAIL pause_hold got=%b exp=%b", {scrolling, paused}, 2'b11); end
    press(3'b001);
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL resume got=%b exp=0", paused); end
    idle(1);
    checks++; if (data_bus !== 16'h4122) begin failures++; $display("FAIL resume_hold got=%h exp=%h", data_bus, 16'h4122); end
    idle(1);
    checks++; if (data_bus !== 16'h1221) begin failures++; $display("FAIL resume_shift got=%h exp=%h", data_bus, 16'h1221); end
  endtask
  task automatic test_load_ignored;
    idle(3);
    press(3'b010);
    checks++; if ({scrolling, number} !== {1'b1, 32'h41221234}) begin failures++; $display("FAIL load_in_scroll got=%b/%h exp=1/%h", scrolling, number, 32'h41221234); end
  endtask
  task automatic test_back;
    idle(3);
    press(3'b100);
    checks++; if ({entry_hi, scrolling, paused} !== 3'b100) begin failures++; $display("FAIL back_flags got=%b exp=%b", {entry_hi, scrolling, paused}, 3'b100); end
    checks++; if (number !== 32'h0) begin failures++; $display("FAIL back_number got=%h exp=%h", number, 32'h0); end
    checks++; if (data_bus !== 16'h1234) begin failures++; $display("FAIL back_preview got=%h exp=%h", data_bus, 16'h1234); end
    sw = 16'h1111;
    idle(3);
    press(3'b010);
    checks++; if (number !== 32'h11110000) begin failures++; $display("FAIL reload_hi got=%h exp=%h", number, 32'h11110000); end
    idle(3);
    press(3'b110);
    checks++; if ({entry_hi, scrolling} !== 2'b10) begin failures++; $display("FAIL back_over_load got=%b exp=%b", {entry_hi, scrolling}, 2'b10); end
    checks++; if (number !== 32'h0) begin failures++; $display("FAIL back_over_load_num got=%h exp=%h", number, 32'h0); end
  endtask
  task automatic test_bcd;
    sw = 16'h12A4;
    idle(3);
    press(3'b010);
`ifdef BCD_CHECK_EN
    checks++; if ({err, entry_hi} !== 2'b11) begin failures++; $display("FAIL bcd_reject got=%b exp=%b", {err, entry_hi}, 2'b11); end
    checks++; if (number !== 32'h0) begin failures++; $display("FAIL bcd_number got=%h exp=%h", number, 32'h0); end
`else
    checks++; if ({err, entry_hi} !== 2'b00) begin failures++; $display("FAIL bcd_accept got=%b exp=%b", {err, entry_hi}, 2'b00); end
    checks++; if (number !== 32'h12A40000) begin failures++; $display("FAIL bcd_number got=%h exp=%h", number, 32'h12A40000); end
`endif
    idle(1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_width got=%b exp=0", err); end
  endtask
  task automatic test_reset_mid;
    idle(3);
    press(3'b100);
    sw = 16'h5678;
    idle(3);
    press(3'b010);
    sw = 16'h9012;
    idle(3);
    press(3'b010);
    checks++; if ({scrolling, number, data_bus} !== {1'b1, 32'h56789012, 16'h5678}) begin failures++; $display("FAIL rescroll got=%b/%h/%h exp=1/%h/%h", scrolling, number, data_bus, 32'h56789012, 16'h5678); end
    idle(5);
    btn_load = 1'b1;
    reset = 1'b1;
    idle(1);
    checks++; if ({number, data_bus} !== {32'h0, 16'hBBBB}) begin failures++; $display("FAIL mid_reset_vals got=%h/%h exp=%h/%h", number, data_bus, 32'h0, 16'hBBBB); end
    checks++; if ({entry_hi, scrolling, paused, err} !== 4'b1000) begin failures++; $display("FAIL mid_reset_flags got=%b exp=%b", {entry_hi, scrolling, paused, err}, 4'b1000); end
    idle(1);
    reset = 1'b0;
    idle(5);
    checks++; if ({entry_hi, number} !== {1'b1, 32'h0}) begin failures++; $display("FAIL held_no_event got=%b/%h exp=1/%h", entry_hi, number, 32'h0); end
    checks++; if (data_bus !== 16'h9012) begin failures++; $display("FAIL post_reset_preview got=%h exp=%h", data_bus, 16'h9012); end
    btn_load = 1'b0;
    sw = 16'h3456;
    idle(3);
    press(3'b010);
    checks++; if ({entry_hi, number} !== {1'b0, 32'h34560000}) begin failures++; $display("FAIL repress got=%b/%h exp=0/%h", entry_hi, number, 32'h34560000); end
  endtask
  initial begin
    test_reset;
    test_load;
    test_scroll;
    test_pause;
    test_load_ignored;
    test_back;
    test_bcd;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msg_scroller.md
# msg_scroller

Source side of the eight-digit seven-segment display path: collects a 32-bit BCD student number from the 16 slide switches in two halves, then produces the 16-bit, four-digit scrolling window on the data bus that the display multiplexer consumes. It also drives the 32-bit number and mode flags used by the upper display digits. It runs entirely in the slow display clock domain.

## Interface
- STEP_CYCLES, 95: clk190hz cycles per scroll step (≈0.5 s); legal 2..1023.
- GAP, 4: blank digits appended after the 8 number digits before wrap; legal 1..8.
- clk190hz  in  1  display clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- sw  in  16  switch bank; four BCD digits, sw[15:12] most significant.
- btn_load  in  1  raw push-button: commit current half.
- btn_run  in  1  raw push-button: pause/resume scrolling.
- btn_back  in  1  raw push-button: abort to high-half entry.
- number  out  32  committed number; number[31:28] = first digit.
- data_bus  out  16  four-digit window; [15:12] leftmost digit, nibble 4'hB = blank.
- entry_hi  out  1  1 while entering the high half.
- scrolling  out  1  1 in SCROLL state, paused or not.
- paused  out  1  1 while scrolling is frozen.
- err  out  1  one-cycle pulse on rejected load (see Configuration).

## Operation
- Buttons: each passes through a 2-flop synchronizer plus a third flop; press event = sync high & delayed low. Holding a button yields one event.
- Priority when events coincide: btn_back > btn_load > btn_run; lower events in that cycle are discarded.
- States: ENTRY_HI, ENTRY_LO, SCROLL.
- ENTRY_HI: entry_hi=1; data_bus <= sw every cycle. Load event: number[31:16] <= sw, go ENTRY_LO.
- ENTRY_LO: entry_hi=0; data_bus <= sw every cycle. Load event: number[15:0] <= sw, pos <= 0, tick <= 0, paused <= 0, go SCROLL.
- SCROLL: message M is L = 8+GAP nibbles, M[i] = number[31-4i -: 4] for i<8, M[i] = 4'hB for i≥8. data_bus = {M[pos], M[(pos+1)%L], M[(pos+2)%L], M[(pos+3)%L]}, registered.
- Tick counts 0..STEP_CYCLES-1 while not paused; at STEP_CYCLES-1 tick wraps to 0 and pos <= (pos+1)%L. pos = L-1 wraps to 0.
- Run event in SCROLL toggles paused; tick and pos hold while paused; resume continues from held tick. Run event in entry states ignored. Load event in SCROLL ignored.
- Back event from any state: go ENTRY_HI, number <= 0, paused <= 0, pos/tick <= 0.
- reset has priority over all events and flushes the synchronizer flops.

## Timing
- Reset values: state ENTRY_HI, number 0, data_bus 16'hBBBB, entry_hi 1, scrolling 0, paused 0, err 0, pos 0, tick 0.
- Button sampled high at edge n by first sync flop → state/register update at edge n+2.
- Entry preview: sw change sampled at edge n appears on data_bus after edge n.
- SCROLL entry edge: data_bus = {number[31:16] digits} i.e. M[0..3]; first shift STEP_CYCLES edges later; thereafter one shift per STEP_CYCLES edges.
- Full cycle of the message repeats every L·STEP_CYCLES cycles.
- err asserted exactly one cycle, coincident with the rejected load's update edge.

## Configuration
- BCD_CHECK_EN defined: a load event with any sw nibble > 9 is rejected — state, number unchanged, err pulses 1 cycle.
- BCD_CHECK_EN undefined: any sw value accepted, err tied 0, no check logic present.

## Test plan
- Reset, sw=16'h4122, load; sw=16'h1234, load → number=32'h41221234, scrolling=1, data_bus=16'h4122 two edges after second press.
- STEP_CYCLES=4, GAP=4 after above → data_bus sequence 4122,1221,2212,2123,1234,234B,34BB,4BBB,BBBB,BBB4,BB41,B412,4122 at 4-cycle spacing.
- Run pressed mid-step (tick=2) → paused=1, data_bus frozen 100 cycles; run again → next shift 2 cycles later.
- Load and back pressed same cycle in ENTRY_LO → ENTRY_HI, number=0, entry_hi=1, no commit.
- With BCD_CHECK_EN, sw=16'h12A4, load in ENTRY_HI → err 1-cycle pulse, stays ENTRY_HI, number=0; without macro → number[31:16]=16'h12A4, err=0.
- reset asserted mid-SCROLL and while btn_load held → all outputs to reset values next edge; no load event after reset release until button released and re-pressed.
